// File: rtl/loadip_pkg.sv
// loadip_pkg: shared FSM encoding and half-buffer depth helper for loadip_feeder
package loadip_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RELEASE} state_t;
  function automatic logic [16:0] depth_of(input int unsigned aw);
    return 17'(1) << aw;
  endfunction
endpackage

// File: rtl/loadip_feeder.sv
// loadip_feeder: streams upstream beats into one half of a ping-pong buffer at a time
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_s_valid/data/last   upstream beat stream, o_s_ready accepts a beat
//   i_wr_ready            per-half write-ready from the buffer
//   i_wr_fifo_size        half capacity reported by the buffer
//   o_wr_activate         one-hot half ownership, 00 when released
//   o_wdata, o_wstrobe    write port into the owned half
//   o_split               sticky flag: a half filled up before the frame ended
//   o_buf_cnt             number of halves committed
module loadip_feeder
  import loadip_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_s_valid,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_last,
  output logic                  o_s_ready,
  input  logic [1:0]            i_wr_ready,
  input  logic [15:0]           i_wr_fifo_size,
  output logic [1:0]            o_wr_activate,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_wstrobe,
  output logic                  o_split,
  output logic [15:0]           o_buf_cnt
);
  localparam logic [16:0] DEPTH = depth_of(ADDR_WIDTH);
  state_t      state;
  logic        r_next;
  logic [15:0] cnt;
  logic [16:0] limit;
  logic [16:0] lim_in;
  logic [16:0] cnt_nxt;
  logic [1:0]  sel;
  // Limit is 17 bits so a full 2^16-deep half is representable.
  assign lim_in    = (i_wr_fifo_size == 16'd0 || {1'b0, i_wr_fifo_size} > DEPTH) ? DEPTH : {1'b0, i_wr_fifo_size};
  assign sel       = i_wr_ready == 2'b11 ? (r_next ? 2'b10 : 2'b01) : i_wr_ready;
  assign cnt_nxt   = {1'b0, cnt} + 17'd1;
  assign o_s_ready = state == FILL && {1'b0, cnt} < limit;
  assign o_wdata   = i_s_data;
  assign o_wstrobe = i_s_valid && o_s_ready;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      o_wr_activate <= 2'b00;
      o_split       <= 1'b0;
      o_buf_cnt     <= 16'd0;
      cnt           <= 16'd0;
      limit         <= DEPTH;
      r_next        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_s_valid && i_wr_ready != 2'b00) begin
          o_wr_activate <= sel;
          limit         <= lim_in;
          cnt           <= 16'd0;
          r_next        <= sel == 2'b01;
          state         <= FILL;
        end
        FILL: if (o_wstrobe) begin
          cnt <= cnt_nxt[15:0];
          if (i_s_last || cnt_nxt == limit) begin
            state         <= RELEASE;
            o_wr_activate <= 2'b00;
            if (!i_s_last) o_split <= 1'b1;
          end
        end
        RELEASE: begin
          o_buf_cnt <= o_buf_cnt + 16'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_loadip_feeder.sv
// tb_loadip_feeder: randomized self-checking bench with a chunk-level reference model
module tb_loadip_feeder;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_s_valid;
  logic [DW-1:0] i_s_data;
  logic          i_s_last;
  logic          o_s_ready;
  logic [1:0]    i_wr_ready;
  logic [15:0]   i_wr_fifo_size;
  logic [1:0]    o_wr_activate;
  logic [DW-1:0] o_wdata;
  logic          o_wstrobe;
  logic          o_split;
  logic [15:0]   o_buf_cnt;
  int            checks = 0;
  int            failures = 0;
  logic          nxt_half = 1'b0;
  int            buf_exp = 0;
  logic          split_exp = 1'b0;

  loadip_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_s_valid(i_s_valid), .i_s_data(i_s_data),
    .i_s_last(i_s_last), .o_s_ready(o_s_ready), .i_wr_ready(i_wr_ready),
    .i_wr_fifo_size(i_wr_fifo_size), .o_wr_activate(o_wr_activate), .o_wdata(o_wdata),
    .o_wstrobe(o_wstrobe), .o_split(o_split), .o_buf_cnt(o_buf_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic test_totals(input string name);
    checks++;
    if (o_buf_cnt !== 16'(buf_exp)) begin
      failures++;
      $display("FAIL %s buf_cnt: got %0d expected %0d", name, o_buf_cnt, buf_exp);
    end
    checks++;
    if (o_split !== split_exp) begin
      failures++;
      $display("FAIL %s split: got %0b expected %0b", name, o_split, split_exp);
    end
  endtask

  // Model: a frame is cut into chunks of at most the clamped limit; each chunk
  // goes to one half, chosen from ready (alternating when both are ready).
  task automatic send_frame(input string name, input int len, input logic [1:0] rdy,
                            input logic [15:0] size, input bit gaps);
    int lim, rem, n, idx, cyc, gap;
    logic [1:0] h;
    logic [DW-1:0] d[$];
    logic [1:0] eh[$];
    bit endc[$];
    lim = (size == 0 || size > DEPTH) ? DEPTH : int'(size);
    rem = len;
    while (rem > 0) begin
      n = rem < lim ? rem : lim;
      h = rdy == 2'b01 ? 2'b01 : rdy == 2'b10 ? 2'b10 : (nxt_half ? 2'b10 : 2'b01);
      nxt_half = h == 2'b01;
      for (int k = 0; k < n; k++) begin
        eh.push_back(h);
        endc.push_back(k == n - 1);
      end
      if (rem > n) split_exp = 1'b1;
      buf_exp++;
      rem -= n;
    end
    for (int k = 0; k < len; k++) d.push_back(DW'($urandom));
    i_wr_ready = rdy;
    i_wr_fifo_size = size;
    idx = 0;
    gap = 0;
    cyc = 0;
    while ((idx < len || gap > 0) && cyc < 400) begin
      i_s_valid = idx < len && (!gaps || $urandom_range(0, 3) != 0);
      i_s_data = idx < len ? d[idx] : '0;
      i_s_last = idx == len - 1;
      @(negedge i_clk);
      cyc++;
      if (gap > 0) begin
        checks++;
        if (o_wr_activate !== 2'b00 || o_wstrobe !== 1'b0) begin
          failures++;
          $display("FAIL %s gap: activate=%b strobe=%b expected 00/0", name, o_wr_activate, o_wstrobe);
        end
        gap--;
      end else if (o_wstrobe) begin
        checks++;
        if (o_wr_activate !== eh[idx] || o_wdata !== d[idx]) begin
          failures++;
          $display("FAIL %s beat%0d: activate=%b data=%h expected %b/%h",
                   name, idx, o_wr_activate, o_wdata, eh[idx], d[idx]);
        end
        if (endc[idx]) gap = 2;
        idx++;
      end
      @(posedge i_clk);
      #1;
    end
    i_s_valid = 1'b0;
    i_s_last = 1'b0;
    if (cyc >= 400) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: wrote %0d of %0d beats", name, idx, len);
    end
    test_totals(name);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_s_valid = 1'b1;
    i_s_data = '0;
    i_s_last = 1'b0;
    i_wr_ready = 2'b11;
    i_wr_fifo_size = 16'd0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_s_ready !== 1'b0 || o_wstrobe !== 1'b0 || o_wr_activate !== 2'b00) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b strobe=%b activate=%b expected 0/0/00", o_s_ready, o_wstrobe, o_wr_activate);
    end
    i_s_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    test_totals("reset");
  endtask

  task automatic test_ready_wait();
    logic [DW-1:0] v;
    v = DW'($urandom);
    i_wr_ready = 2'b00;
    i_wr_fifo_size = 16'd0;
    i_s_valid = 1'b1;
    i_s_data = v;
    i_s_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      checks++;
      if (o_s_ready !== 1'b0 || o_wstrobe !== 1'b0 || o_wr_activate !== 2'b00) begin
        failures++;
        $display("FAIL ready_wait_hold: ready=%b strobe=%b activate=%b expected 0/0/00", o_s_ready, o_wstrobe, o_wr_activate);
      end
      @(posedge i_clk);
      #1;
    end
    i_wr_ready = 2'b10;
    @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_wr_activate !== 2'b10 || o_wstrobe !== 1'b1 || o_wdata !== v) begin
      failures++;
      $display("FAIL ready_wait_acquire: activate=%b strobe=%b data=%h expected 10/1/%h", o_wr_activate, o_wstrobe, o_wdata, v);
    end
    @(posedge i_clk);
    #1;
    i_s_valid = 1'b0;
    i_s_last = 1'b0;
    nxt_half = 1'b0;
    buf_exp++;
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      checks++;
      if (o_wr_activate !== 2'b00) begin
        failures++;
        $display("FAIL ready_wait_release: activate=%b expected 00", o_wr_activate);
      end
      @(posedge i_clk);
      #1;
    end
    test_totals("ready_wait");
  endtask

  task automatic test_mid_reset();
    int beats, cyc;
    beats = 0;
    cyc = 0;
    i_wr_ready = 2'b11;
    i_wr_fifo_size = 16'd0;
    i_s_last = 1'b0;
    while (beats < 2 && cyc < 20) begin
      i_s_valid = 1'b1;
      i_s_data = DW'($urandom);
      @(negedge i_clk);
      cyc++;
      if (o_wstrobe) beats++;
      @(posedge i_clk);
      #1;
    end
    if (beats < 2) begin
      checks++;
      failures++;
      $display("FAIL mid_reset timeout: got %0d beats expected 2", beats);
    end
    i_s_valid = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_wr_activate !== 2'b00 || o_buf_cnt !== 16'd0 || o_s_ready !== 1'b0 || o_split !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: activate=%b buf_cnt=%0d ready=%b split=%b expected 00/0/0/0",
               o_wr_activate, o_buf_cnt, o_s_ready, o_split);
    end
    @(posedge i_clk);
    #1;
    buf_exp = 0;
    split_exp = 1'b0;
    nxt_half = 1'b0;
    send_frame("after_reset", 3, 2'b11, 16'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] r;
    for (int f = 0; f < 25; f++) begin
      r = 2'($urandom_range(1, 3));
      send_frame("random", int'($urandom_range(1, 20)), r, 16'($urandom_range(0, 12)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    send_frame("basic4", 4, 2'b11, 16'd8, 1'b0);
    send_frame("alt_first", 3, 2'b11, 16'd8, 1'b0);
    send_frame("alt_second", 3, 2'b11, 16'd8, 1'b0);
    send_frame("single_beat", 1, 2'b01, 16'd8, 1'b0);
    send_frame("split6", 6, 2'b11, 16'd4, 1'b0);
    test_ready_wait();
    send_frame("clamp_zero", 12, 2'b11, 16'd0, 1'b0);
    send_frame("clamp_big", 10, 2'b11, 16'd300, 1'b0);
    send_frame("stall", 7, 2'b01, 16'd5, 1'b1);
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/loadip_feeder.md
LOADIP_FEEDER -- requirements
Module: loadip_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning width of a data beat.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning half-buffer depth exponent (depth = 2^ADDR_WIDTH).
REQ-003 SHALL have i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have i_s_valid  input  1  upstream beat valid.
REQ-006 SHALL have i_s_data  input  DATA_WIDTH  upstream beat data.
REQ-007 SHALL have i_s_last  input  1  final beat of upstream frame.
REQ-008 SHALL have o_s_ready  output  1  beat accepted when i_s_valid && o_s_ready.
REQ-009 SHALL have i_wr_ready  input  2  per-half ping-pong write-ready from downstream buffer.
REQ-010 SHALL have i_wr_fifo_size  input  16  half-buffer capacity reported by buffer.
REQ-011 SHALL have o_wr_activate  output  2  one-hot half ownership; 00 = released.
REQ-012 SHALL have o_wdata  output  DATA_WIDTH  write data to buffer.
REQ-013 SHALL have o_wstrobe  output  1  write strobe to buffer.
REQ-014 SHALL have o_split  output  1  sticky: a half filled before i_s_last.
REQ-015 SHALL have o_buf_cnt  output  16  count of halves committed (released).

Function
REQ-016 SHALL implement FSM IDLE, FILL, RELEASE; reset state IDLE.
REQ-017 IDLE: when i_s_valid && i_wr_ready != 00, SHALL register o_wr_activate and capture limit; next state FILL; else stay.
REQ-018 Half select: 01 -> half0; 10 -> half1; 11 -> half r_next; r_next toggles on every acquisition to the half opposite the one taken (reset 0).
REQ-019 Limit SHALL be i_wr_fifo_size, clamped to 2^ADDR_WIDTH when 0 or > 2^ADDR_WIDTH; captured once per acquisition.
REQ-020 FILL: o_s_ready = 1 while beat counter < limit; o_s_ready = 0 in IDLE and RELEASE.
REQ-021 o_wdata = i_s_data and o_wstrobe = i_s_valid && o_s_ready, combinational, zero latency; o_wstrobe never high while o_wr_activate == 00.
REQ-022 Beat counter (16-bit) SHALL clear on acquisition and increment per strobe.
REQ-023 On strobe with i_s_last, or strobe making counter == limit: next state RELEASE, o_wr_activate -> 00 next edge.
REQ-024 Fill ending on limit without i_s_last SHALL set o_split; o_split clears only on reset.
REQ-025 RELEASE: exactly one cycle with o_wr_activate = 00, o_buf_cnt += 1 (wraps at 16 bits), then IDLE.
REQ-026 Minimum gap between halves: one RELEASE cycle plus one IDLE cycle; no reacquisition in RELEASE.
REQ-027 i_wr_ready changes during FILL SHALL be ignored; ownership held until RELEASE.
REQ-028 i_s_valid low during FILL SHALL stall without timeout; activate stays asserted.
REQ-029 A 1-beat frame (valid+last on first FILL cycle) SHALL write one beat and release.

Reset
REQ-030 On i_rst high at an edge: state IDLE, o_wr_activate = 00, o_s_ready = 0, o_wstrobe = 0, o_split = 0, o_buf_cnt = 0, counter = 0, r_next = 0.
REQ-031 Reset mid-FILL SHALL drop activate without RELEASE and without incrementing o_buf_cnt; partial data is abandoned.

Structure
REQ-032 Shared package loadip_pkg SHALL hold the FSM state encoding and the depth-from-ADDR_WIDTH constant.
REQ-033 No sub-module; half select and limit clamp inline.

Verification
REQ-034 i_wr_ready=11, 4-beat frame, last on beat 4 -> activate=01, 4 strobes, RELEASE one cycle, o_buf_cnt=1, o_split=0.
REQ-035 i_wr_ready=11, two successive 3-beat frames -> first uses 01, second uses 10.
REQ-036 ADDR_WIDTH=2, size=4, 6-beat frame -> half0 4 beats, o_split=1, half1 2 beats, o_buf_cnt=2.
REQ-037 i_wr_ready=00 with valid held -> o_s_ready=0, no strobe; ready=10 -> activate=10 next edge.
REQ-038 i_rst asserted after 2 beats of FILL -> next edge activate=00, o_buf_cnt=0, state IDLE.
REQ-039 i_wr_fifo_size=0, ADDR_WIDTH=3 -> limit 8, release after 8th beat.
